// File: rtl/muldiv_sequencer_pkg.sv
// Shared types for the MULT/DIV sequencer: FSM state encoding and op-type codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package muldiv_seq_pkg;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_MULT,
    WAIT_DIV,
    COMMIT,
    FAULT_DZ,
    FAULT_TO
  } seq_state_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Bundle of the request, unit-launch/result and HI/LO commit signals around the sequencer.
// Latency: n/a (wiring only).
// Backpressure: op_ready from the sequencer side holds off op_valid requests.
interface muldiv_sequencer_if #(
  parameter int unsigned WIDTH = 32
);

  // Request from the control unit
  logic             op_valid;
  logic             op_type;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_ready;
  logic             abort;

  // Shared multiplier / divider
  logic [WIDTH-1:0] unit_a;
  logic [WIDTH-1:0] unit_b;
  logic             mult_start;
  logic             div_start;
  logic             mult_ready;
  logic             div_ready;
  logic             div_zero;
  logic [WIDTH-1:0] mult_hi;
  logic [WIDTH-1:0] mult_lo;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  // HI/LO commit and status
  logic             hi_wr;
  logic             lo_wr;
  logic [WIDTH-1:0] hi_data;
  logic [WIDTH-1:0] lo_data;
  logic             done;
  logic             exc_div_zero;
  logic             exc_timeout;
  logic             busy;

  // Environment side: control unit plus the two arithmetic units
  modport master (
    output op_valid, op_type, op_a, op_b, abort,
    output mult_ready, div_ready, div_zero, mult_hi, mult_lo, div_hi, div_lo,
    input  op_ready, unit_a, unit_b, mult_start, div_start,
    input  hi_wr, lo_wr, hi_data, lo_data, done, exc_div_zero, exc_timeout, busy
  );

  // Sequencer side
  modport slave (
    input  op_valid, op_type, op_a, op_b, abort,
    input  mult_ready, div_ready, div_zero, mult_hi, mult_lo, div_hi, div_lo,
    output op_ready, unit_a, unit_b, mult_start, div_start,
    output hi_wr, lo_wr, hi_data, lo_data, done, exc_div_zero, exc_timeout, busy
  );

endinterface

// File: rtl/muldiv_sequencer_watchdog.sv
// Cycle counter that flags when a unit has been waited on for TIMEOUT_CYCLES cycles.
// Latency: expired is a decode of the count register; count updates one cycle after enable.
// Backpressure: none; clear has priority over enable.
module cycle_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 40,
  parameter int unsigned CNT_W          = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: restart on clear, otherwise advance while the owner is waiting
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The owner leaves its wait state when this fires, so the count never wraps.
  assign expired = (cnt_q == LAST_CNT);

endmodule

// File: rtl/muldiv_sequencer.sv
// Launches one MULT/DIV on the shared units, waits for ready under a watchdog, commits HI/LO.
// Latency: start 1 cycle after accept; commit 1 cycle after ready is sampled; idle the cycle after.
// Backpressure: op_ready low (busy) from accept until back in IDLE; abort also holds off accept.
module muldiv_sequencer
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 40,
  parameter int unsigned CNT_W          = 6
) (
  input  logic                clk,
  input  logic                reset,
  muldiv_sequencer_if.slave   bus
);

  seq_state_e       state_q, state_d;
  logic             op_type_q, op_type_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic wd_clear;
  logic wd_en;
  logic wd_expired;
  logic op_ready;
  logic accept;
  logic commit;

  // Abort in IDLE must block the accept in the same cycle, hence the only input-to-output path.
  assign op_ready = (state_q == IDLE) && !bus.abort;
  assign accept   = bus.op_valid && op_ready;

  cycle_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (reset),
    .clear   (wd_clear),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  // Next state, operand capture and result capture; priority abort > div_zero > ready > timeout
  always_comb begin
    state_d   = state_q;
    op_type_d = op_type_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    wd_clear  = 1'b0;
    wd_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d       = bus.op_a;
          b_d       = bus.op_b;
          op_type_d = bus.op_type;
          // A zero divisor is caught here so the divider is never launched.
          if ((bus.op_type == OP_DIV) && (bus.op_b == '0)) begin
            state_d = FAULT_DZ;
          end else begin
            state_d = LAUNCH;
          end
        end
      end

      LAUNCH: begin
        wd_clear = 1'b1;
        if (bus.abort) begin
          state_d = IDLE;
        end else if (op_type_q == OP_DIV) begin
          state_d = WAIT_DIV;
        end else begin
          state_d = WAIT_MULT;
        end
      end

      WAIT_MULT: begin
        wd_en = 1'b1;
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.mult_ready) begin
          hi_d    = bus.mult_hi;
          lo_d    = bus.mult_lo;
          state_d = COMMIT;
        end else if (wd_expired) begin
          state_d = FAULT_TO;
        end
      end

      WAIT_DIV: begin
        wd_en = 1'b1;
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.div_zero) begin
          state_d = FAULT_DZ;
        end else if (bus.div_ready) begin
          hi_d    = bus.div_hi;
          lo_d    = bus.div_lo;
          state_d = COMMIT;
        end else if (wd_expired) begin
          state_d = FAULT_TO;
        end
      end

      COMMIT, FAULT_DZ, FAULT_TO: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, operand and result registers; reset drops any in-flight operation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_type_q <= OP_MULT;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      op_type_q <= op_type_d;
      a_q       <= a_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign commit = (state_q == COMMIT);

  assign bus.op_ready     = op_ready;
  assign bus.busy         = !op_ready;
  assign bus.unit_a       = a_q;
  assign bus.unit_b       = b_q;
  assign bus.mult_start   = (state_q == LAUNCH) && (op_type_q == OP_MULT);
  assign bus.div_start    = (state_q == LAUNCH) && (op_type_q == OP_DIV);
  assign bus.hi_wr        = commit;
  assign bus.lo_wr        = commit;
  assign bus.done         = commit;
  // Result registers only change on the ready edge that leads into COMMIT,
  // so they double as the "last committed value" outside COMMIT.
  assign bus.hi_data      = hi_q;
  assign bus.lo_data      = lo_q;
  assign bus.exc_div_zero = (state_q == FAULT_DZ);
  assign bus.exc_timeout  = (state_q == FAULT_TO);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomised bench for muldiv_sequencer against a transaction-level outcome model.
// Latency: n/a.
// Backpressure: n/a.
module tb_muldiv_sequencer;
  import muldiv_seq_pkg::*;

  localparam int TIMEOUT = 40;
  localparam int O_CM = 0;
  localparam int O_DZ = 1;
  localparam int O_TO = 2;
  localparam int O_AB = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(32)) bus();

  muldiv_sequencer #(
    .WIDTH          (32),
    .TIMEOUT_CYCLES (TIMEOUT),
    .CNT_W          (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_cmp = 0;
  int          n_mis = 0;
  int          op_idx = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ctl_vec();
    return {23'd0, bus.mult_start, bus.div_start, bus.hi_wr, bus.lo_wr, bus.done,
            bus.exc_div_zero, bus.exc_timeout, bus.op_ready, bus.busy};
  endfunction

  function automatic logic [31:0] mk_ctl(input bit ms, input bit ds, input bit cm,
                                         input bit dz, input bit to, input bit rdy);
    return {23'd0, ms, ds, cm, cm, cm, dz, to, rdy, !rdy};
  endfunction

  task automatic unit_idle();
    bus.mult_ready = 1'b0;
    bus.div_ready  = 1'b0;
    bus.div_zero   = 1'b0;
    bus.mult_hi    = $urandom;
    bus.mult_lo    = $urandom;
    bus.div_hi     = $urandom;
    bus.div_lo     = $urandom;
  endtask

  // One IDLE cycle; when blocked, a request is offered together with abort and must be refused.
  task automatic idle_cycle(input bit blocked);
    @(posedge clk); #1;
    bus.op_valid = blocked;
    bus.abort    = blocked;
    bus.op_type  = 1'($urandom);
    bus.op_a     = $urandom;
    bus.op_b     = $urandom;
    unit_idle();
    @(negedge clk);
    check_val($sformatf("idle ctl blk=%0d", blocked), ctl_vec(), mk_ctl(0, 0, 0, 0, 0, !blocked));
    check_val("idle hi_data", bus.hi_data, last_hi);
    check_val("idle lo_data", bus.lo_data, last_lo);
  endtask

  // One request from accept to its final cycle. delay: cycles from start to the selected
  // unit's ready (<=0: never). abort_c / dz_c / reset_at: cycle numbers relative to accept (0: none).
  task automatic run_op(input logic typ, input logic [31:0] a, input logic [31:0] b,
                        input int delay, input int abort_c, input int dz_c, input int reset_at);
    logic signed [63:0] sa, sb, prod;
    logic signed [31:0] qa, qb;
    logic [31:0]        rhi, rlo;
    int                 k, outc, endc;
    bit                 dz0;
    string              t;

    // Reference results from plain signed arithmetic
    sa   = $signed(a);
    sb   = $signed(b);
    prod = sa * sb;
    rhi  = '0;
    rlo  = '0;
    if (typ == OP_MULT) begin
      rhi = prod[63:32];
      rlo = prod[31:0];
    end else if (b != 0) begin
      qa  = a;
      qb  = b;
      rlo = qa / qb;
      rhi = qa % qb;
    end

    // Outcome: which event wins first and in which cycle the operation ends
    k    = (delay > 0) ? 1 + delay : -1;
    dz0  = (typ == OP_DIV) && (b == 0);
    outc = O_TO;
    endc = 2 + TIMEOUT;
    if (dz0) begin
      outc = O_DZ;
      endc = 1;
    end else if (abort_c == 1) begin
      outc = O_AB;
      endc = 1;
    end else begin
      for (int w = 2; w <= 1 + TIMEOUT; w++) begin
        if (w == abort_c) begin
          outc = O_AB; endc = w; break;
        end
        if ((typ == OP_DIV) && (w == dz_c)) begin
          outc = O_DZ; endc = w + 1; break;
        end
        if (w == k) begin
          outc = O_CM; endc = w + 1; break;
        end
      end
    end

    op_idx++;
    @(posedge clk); #1;
    bus.op_valid = 1'b1;
    bus.op_type  = typ;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.abort    = 1'b0;
    unit_idle();
    @(negedge clk);
    check_val($sformatf("op%0d accept ctl", op_idx), ctl_vec(), mk_ctl(0, 0, 0, 0, 0, 1));

    for (int n = 1; n <= endc; n++) begin
      @(posedge clk); #1;
      bus.op_valid = 1'($urandom);
      bus.op_type  = 1'($urandom);
      bus.op_a     = $urandom;
      bus.op_b     = $urandom;
      bus.abort    = (n == abort_c);
      if (typ == OP_MULT) begin
        bus.mult_ready = (n == k);
        bus.mult_hi    = (n == k) ? rhi : $urandom;
        bus.mult_lo    = (n == k) ? rlo : $urandom;
        bus.div_ready  = 1'($urandom);
        bus.div_zero   = 1'($urandom);
        bus.div_hi     = $urandom;
        bus.div_lo     = $urandom;
      end else begin
        bus.div_ready  = (n == k);
        bus.div_zero   = (n == dz_c);
        bus.div_hi     = (n == k) ? rhi : $urandom;
        bus.div_lo     = (n == k) ? rlo : $urandom;
        bus.mult_ready = 1'($urandom);
        bus.mult_hi    = $urandom;
        bus.mult_lo    = $urandom;
      end

      if (n == reset_at) begin
        bus.abort    = 1'b0;
        bus.op_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        last_hi = '0;
        last_lo = '0;
        t = $sformatf("op%0d reset", op_idx);
        check_val({t, " ctl"}, ctl_vec(), mk_ctl(0, 0, 0, 0, 0, 1));
        check_val({t, " unit_a"}, bus.unit_a, 32'd0);
        check_val({t, " unit_b"}, bus.unit_b, 32'd0);
        check_val({t, " hi_data"}, bus.hi_data, 32'd0);
        check_val({t, " lo_data"}, bus.lo_data, 32'd0);
        unit_idle();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        return;
      end

      @(negedge clk);
      if ((n == endc) && (outc == O_CM)) begin
        last_hi = rhi;
        last_lo = rlo;
      end
      t = $sformatf("op%0d c%0d", op_idx, n);
      check_val({t, " ctl"}, ctl_vec(),
                mk_ctl((n == 1) && (typ == OP_MULT) && !dz0,
                       (n == 1) && (typ == OP_DIV) && !dz0,
                       (n == endc) && (outc == O_CM),
                       (n == endc) && (outc == O_DZ),
                       (n == endc) && (outc == O_TO),
                       1'b0));
      check_val({t, " unit_a"}, bus.unit_a, a);
      check_val({t, " unit_b"}, bus.unit_b, b);
      check_val({t, " hi_data"}, bus.hi_data, last_hi);
      check_val({t, " lo_data"}, bus.lo_data, last_lo);
    end
  endtask

  initial begin
    logic        typ;
    logic [31:0] a, b;
    int          dly, ab, dz;

    bus.op_valid = 1'b0;
    bus.op_type  = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.abort    = 1'b0;
    unit_idle();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset ctl", ctl_vec(), mk_ctl(0, 0, 0, 0, 0, 1));
    check_val("reset unit_a", bus.unit_a, 32'd0);
    check_val("reset unit_b", bus.unit_b, 32'd0);
    check_val("reset hi_data", bus.hi_data, 32'd0);
    check_val("reset lo_data", bus.lo_data, 32'd0);
    reset = 1'b1;
    idle_cycle(1'b0);

    // Directed cases, back to back
    run_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, 32, 0, 0, 0);
    run_op(OP_DIV, 32'd100, 32'd7, 33, 0, 0, 0);
    run_op(OP_DIV, 32'd5, 32'd0, 10, 0, 0, 0);
    run_op(OP_MULT, $urandom, $urandom, 0, 0, 0, 0);
    run_op(OP_DIV, 32'd1000, 32'd9, 0, 0, 0, 0);
    run_op(OP_DIV, 32'd1000, 32'd9, TIMEOUT, 0, 0, 0);
    run_op(OP_MULT, 32'd123, 32'd456, TIMEOUT + 1, 0, 0, 0);
    run_op(OP_MULT, 32'd3, 32'd5, 10, 11, 0, 0);
    run_op(OP_MULT, 32'h8000_0001, 32'd12345, 5, 0, 0, 0);
    run_op(OP_DIV, 32'hFFFF_FF00, 32'd13, 20, 0, 8, 0);
    run_op(OP_DIV, 32'd77, 32'd3, 6, 0, 7, 0);
    run_op(OP_MULT, 32'd9, 32'd9, 4, 1, 0, 0);
    idle_cycle(1'b1);
    idle_cycle(1'b0);
    run_op(OP_DIV, 32'd50, 32'd6, 0, 0, 0, 8);
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    run_op(OP_DIV, 32'd50, 32'd6, 3, 0, 0, 0);

    // Randomised requests
    for (int i = 0; i < 40; i++) begin
      typ = 1'($urandom);
      a   = $urandom;
      b   = $urandom;
      if ((typ == OP_DIV) && ($urandom_range(5, 0) == 0)) b = '0;
      if (b == 32'hFFFF_FFFF) b = 32'd7;
      dly = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(TIMEOUT + 5, 1));
      ab  = ($urandom_range(4, 0) == 0) ? int'($urandom_range(TIMEOUT + 4, 1)) : 0;
      dz  = ((typ == OP_DIV) && ($urandom_range(5, 0) == 0)) ? int'($urandom_range(TIMEOUT + 4, 2)) : 0;
      run_op(typ, a, b, dly, ab, dz, 0);
      for (int g = 0; g < int'($urandom_range(2, 0)); g++) begin
        idle_cycle(1'($urandom));
      end
    end
    idle_cycle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
